bias_add_stage: RTL and testbench

- Consumer of a per-layer bias bank. Takes one beat of N_adder_tree accumulator lanes from the adder tree and adds the matching 18-bit bias lane to each one.
- Per lane: saturates the result to 18 bits, applies optional ReLU, and forwards the result downstream.
- Tracks which output-channel group is active (grp_idx) so the layer top can mux the correct bias-bank instance onto bias_in.
- Sits between the adder tree and the next layer's input buffer.

---
 rtl/bias_add_stage_pkg.sv | 25 ++
 rtl/bias_lane_sat.sv | 45 ++++
 rtl/bias_add_stage.sv | 95 +++++++++
 tb/tb_bias_add_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_stage_pkg.sv
// Layer-common lane format: width, saturation limits and the W+1 -> W saturating narrow.
package bias_add_stage_pkg;

    localparam int LANE_W = 18;

    localparam logic [LANE_W-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [LANE_W-1:0] SAT_MIN = 18'h20000;

    typedef logic signed [LANE_W:0]   sum_t;
    typedef logic signed [LANE_W-1:0] lane_t;

    // The two top bits of a W+1-bit sum disagree only when it no longer fits in W bits.
    function automatic lane_t sat_w(input sum_t sum);
        lane_t res;
        if (!sum[LANE_W] && sum[LANE_W-1]) begin
            res = lane_t'(SAT_MAX);
        end else if (sum[LANE_W] && !sum[LANE_W-1]) begin
            res = lane_t'(SAT_MIN);
        end else begin
            res = sum[LANE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bias_lane_sat.sv
// One lane of the bias stage: add bias, then saturate and optional ReLU, as a two-register slice.
module bias_lane_sat
    import bias_add_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     relu_en,
    input  logic signed [LANE_W-1:0] acc,
    input  logic signed [LANE_W-1:0] bias,
    output logic signed [LANE_W-1:0] out_lane
);

    logic signed [LANE_W:0]   r_sum_p1;
    logic signed [LANE_W-1:0] r_res_p2;
    logic signed [LANE_W-1:0] w_sat;

    // ReLU runs after saturation, so a negative-saturated lane still clamps to zero.
    function automatic lane_t relu(input lane_t x, input logic enable);
        lane_t res;
        res = (enable && x[LANE_W-1]) ? '0 : x;
        return res;
    endfunction

    assign w_sat = sat_w(r_sum_p1);

    // stage p1: full-precision sum
    always_ff @(posedge clk) begin
        if (en) begin
            r_sum_p1 <= {acc[LANE_W-1], acc} + {bias[LANE_W-1], bias};
        end
    end

    // stage p2: saturate + ReLU; cleared on reset so out_data reads 0 afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_p2 <= '0;
        end else if (en) begin
            r_res_p2 <= relu(w_sat, relu_en);
        end
    end

    assign out_lane = r_res_p2;

endmodule

// File: rtl/bias_add_stage.sv
// Adds the per-group bias bank to each adder-tree lane, saturates, optional ReLU, and tracks
// which output-channel group is active so the layer top can select the matching bias bank.
module bias_add_stage
    import bias_add_stage_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int W            = LANE_W,
    parameter int PIX_PER_GRP  = 196,
    parameter int N_GRP        = 39,
    parameter int GRP_W        = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      relu_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_adder_tree*W-1:0] acc_in,
    input  logic [N_adder_tree*W-1:0] bias_in,
    output logic [GRP_W-1:0]          grp_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic                      grp_done
);

    localparam int CNT_W = (PIX_PER_GRP > 1) ? $clog2(PIX_PER_GRP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_PER_GRP - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N_GRP - 1);

    logic             w_en;
    logic             w_xfer;
    logic             w_last_beat;
    logic             r_vld_p1;
    logic             r_vld_p2;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [GRP_W-1:0] r_grp_idx;
    logic             r_grp_done;

    // The whole pipeline freezes only when a finished result is waiting on downstream.
    assign w_en        = !(r_vld_p2 && !out_ready);
    assign in_ready    = w_en;
    assign w_xfer      = in_valid && w_en;
    assign w_last_beat = (r_beat_cnt == CNT_LAST);

    genvar k;
    generate
        for (k = 0; k < N_adder_tree; k++) begin : g_lane
            bias_lane_sat u_lane (
                .clk      (clk),
                .rst      (rst),
                .en       (w_en),
                .relu_en  (relu_en),
                .acc      (acc_in[W*k +: W]),
                .bias     (bias_in[W*k +: W]),
                .out_lane (out_data[W*k +: W])
            );
        end
    endgenerate

    // stage p1/p2 valid bits; bubbles travel like data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // group tracking: grp_idx moves the cycle after the last beat, so beat 1 of the
    // next group already sees the new bias bank on bias_in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_grp_idx  <= '0;
            r_grp_done <= 1'b0;
        end else begin
            r_grp_done <= w_xfer && w_last_beat;
            if (w_xfer) begin
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_grp_idx  <= (r_grp_idx == GRP_LAST) ? '0 : r_grp_idx + 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign grp_idx   = r_grp_idx;
    assign grp_done  = r_grp_done;

endmodule

// File: tb/tb_bias_add_stage.sv
// Scoreboard bench for bias_add_stage with small group geometry (4 beats/group, 3 groups).
module tb_bias_add_stage;

    localparam int NL   = 16;
    localparam int LW   = 18;
    localparam int BW   = NL * LW;
    localparam int PPG  = 4;
    localparam int NG   = 3;
    localparam int GW   = 6;

    logic          clk;
    logic          rst;
    logic          relu_en;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] acc_in;
    logic [BW-1:0] bias_in;
    logic [GW-1:0] grp_idx;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          grp_done;

    bias_add_stage #(
        .N_adder_tree (NL),
        .W            (LW),
        .PIX_PER_GRP  (PPG),
        .N_GRP        (NG),
        .GRP_W        (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .bias_in   (bias_in),
        .grp_idx   (grp_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .grp_done  (grp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] bank [NG];

    always_comb begin
        bias_in = '0;
        if (int'(grp_idx) < NG) bias_in = bank[int'(grp_idx)];
    end

    int            n_total = 0;
    int            n_bad   = 0;
    logic [BW-1:0] q [$];
    logic [BW-1:0] last_out;
    logic [BW-1:0] r_acc;
    logic          r_relu;
    int            m_cnt, m_grp, n_acc, n_done_seen;
    logic          m_v1, m_v2, m_done, m_en;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                            input logic relu);
        logic [BW-1:0] res;
        logic [LW-1:0] r;
        int av, bv, s;
        res = '0;
        for (int k = 0; k < NL; k++) begin
            av = $signed(a[k*LW +: LW]);
            bv = $signed(b[k*LW +: LW]);
            s  = av + bv;
            if (s > 131071)       r = 18'h1FFFF;
            else if (s < -131072) r = 18'h20000;
            else                  r = LW'(s);
            if (relu && r[LW-1]) r = '0;
            res[k*LW +: LW] = r;
        end
        return res;
    endfunction

    function automatic logic [LW-1:0] rand_lane();
        logic [LW-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 18'h1FFFF;
            1:       v = 18'h20000;
            2:       v = 18'h3FFFF;
            default: v = LW'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*LW +: LW] = rand_lane();
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_grp = 0; m_v1 = 0; m_v2 = 0; m_done = 0;
        q.delete();
    endtask

    // One clock: drive at negedge, check the state left by the previous edge, then
    // advance the model exactly as the coming posedge will.
    task automatic step(input logic iv, input logic orr);
        @(negedge clk);
        in_valid  = iv;
        out_ready = orr;
        acc_in    = r_acc;
        relu_en   = r_relu;
        #1;
        chk("out_valid", out_valid, m_v2);
        chk("grp_idx", grp_idx, m_grp);
        chk("grp_done", grp_done, m_done);
        if (grp_done) n_done_seen++;
        m_en = !(m_v2 && !orr);
        chk("in_ready", in_ready, m_en);
        if (m_v2) begin
            if (q.size() == 0) begin
                chk("q_underflow", 1, 0);
            end else begin
                chk("out_data", out_data, q[0]);
                if (orr) begin
                    last_out = out_data;
                    void'(q.pop_front());
                end
            end
        end
        m_done = 1'b0;
        if (m_en) begin
            if (iv) begin
                q.push_back(model(r_acc, bank[m_grp], r_relu));
                n_acc++;
                if (m_cnt == PPG - 1) begin
                    m_done = 1'b1;
                    m_cnt  = 0;
                    m_grp  = (m_grp == NG - 1) ? 0 : m_grp + 1;
                end else begin
                    m_cnt++;
                end
            end
            m_v2 = m_v1;
            m_v1 = iv;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_in = '0;
        r_acc = '0; r_relu = 1'b0; n_acc = 0; n_done_seen = 0; last_out = '0;
        for (int g = 0; g < NG; g++) bank[g] = rand_beat();
        bank[0][0*LW +: LW] = 18'h3FA60;
        bank[0][1*LW +: LW] = 18'h3FA60;
        bank[0][9*LW +: LW] = 18'h07D5C;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_grp_idx", grp_idx, 0);
        chk("rst_grp_done", grp_done, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        // directed lanes, relu off then on
        r_acc = '0;
        r_acc[0*LW +: LW] = 18'h003E8;
        r_acc[1*LW +: LW] = 18'h20000;
        r_acc[9*LW +: LW] = 18'h1FFFF;
        step(1'b1, 1'b1);
        drain();
        chk("lane0_norelu", last_out[0*LW +: LW], 18'h3FE48);
        chk("lane1_negsat", last_out[1*LW +: LW], 18'h20000);
        chk("lane9_possat", last_out[9*LW +: LW], 18'h1FFFF);
        r_relu = 1'b1;
        step(1'b1, 1'b1);
        drain();
        chk("lane0_relu", last_out[0*LW +: LW], 18'h00000);
        chk("lane1_negsat_relu", last_out[1*LW +: LW], 18'h00000);
        chk("lane9_possat_relu", last_out[9*LW +: LW], 18'h1FFFF);
        r_relu = 1'b0;

        // back-pressure: continuous input, downstream stalled for 5 cycles
        for (int i = 0; i < 10; i++) begin
            r_acc = rand_beat();
            step(1'b1, (i >= 2 && i < 7) ? 1'b0 : 1'b1);
        end
        drain();
        chk("bp_drained", q.size(), 0);

        // reset with both stages holding valid beats
        for (int i = 0; i < 3; i++) begin
            r_acc = rand_beat();
            step(1'b1, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_grp_idx", grp_idx, 0);
        chk("midrst_grp_done", grp_done, 0);
        chk("midrst_in_ready", in_ready, 1);
        model_reset();

        // group wrap: 12 beats -> three grp_done pulses, grp_idx back to 0
        n_done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            r_acc = rand_beat();
            step(1'b1, 1'b1);
        end
        drain();
        chk("wrap_done_pulses", n_done_seen, 3);
        chk("wrap_grp_idx", grp_idx, 0);

        // random traffic, relu toggled at the halfway point after a drain
        begin
            int cycles;
            cycles = 0;
            n_acc  = 0;
            while (n_acc < 10000 && cycles < 60000) begin
                if (n_acc >= 5000 && !r_relu) begin
                    drain();
                    r_relu = 1'b1;
                end
                r_acc = rand_beat();
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
                cycles++;
            end
            if (n_acc < 10000) chk("rand_budget", n_acc, 10000);
        end
        drain();
        chk("final_q_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
